sa_result_drain: RTL and testbench

Output-side drain for the systolic array: captures one full row of N accumulator results in a single cycle and streams them out one element per cycle over a valid/ready interface. It sits between the array's result registers and downstream consumers (writeback / host readout). Two internal banks let the array deposit the next row while the previous row is still draining.

---
 rtl/sa_result_drain.sv | 110 +++++++++++
 tb/tb_sa_result_drain.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Systolic-array result drain: two-bank row capture, one element per cycle out.
// A bank is refilled while the other drains, so sustained rows stream without bubbles.

module sa_drain_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic                  wr_bank_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_bank_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  logic [1:0][DATA_WIDTH-1:0] bank_q;

  always_ff @(posedge clk) begin
    if (reset)        bank_q            <= '0;
    else if (wr_en_i) bank_q[wr_bank_i] <= wr_data_i;
  end

  assign rd_data_o = bank_q[rd_bank_i];
endmodule

module sa_result_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  localparam int IDX_W     = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cap_valid_i,
  input  logic [N*DATA_WIDTH-1:0] cap_data_i,
  output logic                    cap_ready_o,
  output logic                    out_valid_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [IDX_W-1:0]        out_idx_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    overflow_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  occ_e             state_q, state_d;
  logic             wp_q, wp_d, rp_q, rp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overflow_q, overflow_d;

  logic [N-1:0][DATA_WIDTH-1:0] lane_rd;
  logic cap_fire, pop, last_pop, at_last;

  assign cap_ready_o = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign at_last     = (idx_q == IDX_W'(N-1));
  assign cap_fire    = cap_valid_i && cap_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign last_pop    = pop && at_last;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sa_drain_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (cap_fire),
      .wr_bank_i (wp_q),
      .wr_data_i (cap_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_bank_i (rp_q),
      .rd_data_o (lane_rd[i])
    );
  end

  // Outputs are forced to zero when nothing is buffered so stale bank data never leaks.
  assign out_data_o = out_valid_o ? lane_rd[idx_q] : '0;
  assign out_idx_o  = out_valid_o ? idx_q : '0;
  assign out_last_o = out_valid_o && at_last;
  assign overflow_o = overflow_q;

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q ^ cap_fire;
    rp_d       = rp_q ^ last_pop;
    idx_d      = idx_q;
    overflow_d = overflow_q | (cap_valid_i && !cap_ready_o);
    if (pop) idx_d = at_last ? '0 : idx_q + 1'b1;
    case (state_q)
      EMPTY:   if (cap_fire) state_d = ONE;
      ONE: begin
        if (cap_fire && !last_pop)      state_d = FULL;
        else if (!cap_fire && last_pop) state_d = EMPTY;
      end
      FULL:    if (last_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: directed scenarios plus random traffic vs a row-queue model.
module tb_sa_result_drain;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int VW = 1 + 1 + DW + IW + 1 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cap_valid;
  logic [N*DW-1:0] cap_data;
  logic          cap_ready, out_valid, out_last, out_ready, overflow;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of whole rows (depth 2) and position within head row
  logic [N*DW-1:0] rowq[$];
  int              pos;
  logic            m_ovf;

  sa_result_drain #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .reset(reset),
    .cap_valid_i(cap_valid), .cap_data_i(cap_data), .cap_ready_o(cap_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_idx_o(out_idx),
    .out_last_o(out_last), .out_ready_i(out_ready), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] gotv = {cap_ready, out_valid, out_data, out_idx, out_last, overflow};

  function automatic logic [VW-1:0] expv();
    logic          v, l;
    logic [DW-1:0] d;
    logic [IW-1:0] ix;
    logic [N*DW-1:0] head;
    v = rowq.size() > 0;
    d = '0; ix = '0; l = 1'b0;
    if (v) begin
      head = rowq[0];
      d  = head[pos*DW +: DW];
      ix = IW'(pos);
      l  = (pos == N-1);
    end
    return {rowq.size() < 2, v, d, ix, l, m_ovf};
  endfunction

  function automatic logic [N*DW-1:0] mkrow(input logic [DW-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Drive one cycle's inputs at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic r, input logic cv, input logic [N*DW-1:0] cd, input logic ordy);
    logic v, rdy;
    reset = r; cap_valid = cv; cap_data = cd; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      rowq.delete(); pos = 0; m_ovf = 1'b0;
    end else begin
      v   = rowq.size() > 0;
      rdy = rowq.size() < 2;
      if (cv && !rdy) m_ovf = 1'b1;
      if (v && ordy) begin
        if (pos == N-1) begin pos = 0; void'(rowq.pop_front()); end
        else pos++;
      end
      if (cv && rdy) rowq.push_back(cd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1, 1, mkrow(16'h1, 16'h2, 16'h3, 16'h4), 1);
    cyc(1, 0, '0, 0);
    checks++;
    if (gotv !== {1'b1, 1'b0, {DW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %h exp %h", gotv, {1'b1, 1'b0, {DW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0});
    end
  endtask

  task automatic test_basic();
    cyc(0, 1, mkrow(16'h1, 16'h2, 16'h3, 16'h4), 1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (!(out_valid === 1'b1 && out_data === DW'(i+1) && out_idx === IW'(i) && out_last === (i == N-1))) begin
        errors++; $display("FAIL basic_elem%0d: got v=%b d=%h i=%0d l=%b", i, out_valid, out_data, out_idx, out_last);
      end
      cyc(0, 0, '0, 1);
    end
    checks++;
    if (gotv !== expv() || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_empty: got %h exp %h", gotv, expv());
    end
  endtask

  task automatic test_back_to_back();
    cyc(0, 1, mkrow(16'hA0, 16'hA1, 16'hA2, 16'hA3), 0);
    cyc(0, 1, mkrow(16'hB0, 16'hB1, 16'hB2, 16'hB3), 0);
    checks++;
    if (cap_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: got cap_ready=%b exp 0", cap_ready);
    end
    // Offer C while full: must be dropped and flag overflow
    cyc(0, 1, mkrow(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0);
    checks++;
    if (overflow !== 1'b1 || gotv !== expv()) begin
      errors++; $display("FAIL overflow_set: got %h exp %h", gotv, expv());
    end
    for (int i = 0; i < 2*N; i++) begin
      logic [DW-1:0] want;
      want = (i < N) ? DW'(16'hA0 + i) : DW'(16'hB0 + i - N);
      checks++;
      if (out_valid !== 1'b1 || out_data !== want || overflow !== 1'b1) begin
        errors++; $display("FAIL b2b_stream%0d: got v=%b d=%h ovf=%b exp d=%h", i, out_valid, out_data, overflow, want);
      end
      cyc(0, 0, '0, 1);
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_drained: got v=%b ovf=%b exp v=0 ovf=1", out_valid, overflow);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] seen[$];
    logic          pat[12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    logic [DW-1:0] held;
    cyc(1, 0, '0, 0);
    cyc(0, 1, mkrow(16'h11, 16'h22, 16'h33, 16'h44), 0);
    held = out_data;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (gotv !== expv()) begin
        errors++; $display("FAIL stall_cyc%0d: got %h exp %h", i, gotv, expv());
      end
      if (i > 0 && !pat[i-1] && out_valid && out_data !== held) begin
        checks++; errors++; $display("FAIL stall_hold%0d: got %h exp %h", i, out_data, held);
      end
      held = out_data;
      if (out_valid && pat[i]) seen.push_back(out_data);
      cyc(0, 0, '0, pat[i]);
    end
    checks++;
    if (seen.size() != N || seen[0] !== 16'h11 || seen[1] !== 16'h22 || seen[2] !== 16'h33 || seen[3] !== 16'h44) begin
      errors++; $display("FAIL stall_seq: got %0d elems first %h exp 11,22,33,44", seen.size(), (seen.size() > 0) ? seen[0] : 16'h0);
    end
  endtask

  task automatic test_simul();
    cyc(0, 1, mkrow(16'h51, 16'h52, 16'h53, 16'h54), 1);
    for (int i = 0; i < N-1; i++) cyc(0, 0, '0, 1);
    checks++;
    if (out_idx !== IW'(N-1) || out_last !== 1'b1) begin
      errors++; $display("FAIL simul_pre: got idx=%0d last=%b exp idx=%0d last=1", out_idx, out_last, N-1);
    end
    cyc(0, 1, mkrow(16'h61, 16'h62, 16'h63, 16'h64), 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h61 || out_idx !== '0 || cap_ready !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL simul_post: got %h exp v=1 d=0061 idx=0 rdy=1", gotv);
    end
    for (int i = 0; i < N; i++) cyc(0, 0, '0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL simul_drain: got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, mkrow(16'h71, 16'h72, 16'h73, 16'h74), 1);
    cyc(0, 1, mkrow(16'h81, 16'h82, 16'h83, 16'h84), 1);
    cyc(0, 1, mkrow(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0);
    cyc(1, 1, mkrow(16'h91, 16'h92, 16'h93, 16'h94), 1);
    checks++;
    if (out_valid !== 1'b0 || cap_ready !== 1'b1 || overflow !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset_mid: got %h exp v=0 rdy=1 ovf=0", gotv);
    end
    cyc(0, 1, mkrow(16'hC0, 16'hC1, 16'hC2, 16'hC3), 0);
    checks++;
    if (out_data !== 16'hC0 || out_idx !== '0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_fresh: got d=%h idx=%0d exp d=00c0 idx=0", out_data, out_idx);
    end
  endtask

  task automatic test_random();
    logic [N*DW-1:0] rd;
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom};
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, rd, $urandom_range(0, 3) != 0);
      checks++;
      if (gotv !== expv()) begin
        errors++; $display("FAIL random_cyc%0d: got %h exp %h", i, gotv, expv());
      end
    end
  endtask

  initial begin
    pos = 0; m_ovf = 1'b0;
    reset = 1'b1; cap_valid = 1'b0; cap_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
